// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo write port among
// N_REQ producers. A requester owns the port for a burst of up to BURST
// accepted words, and one idle cycle separates bursts while the next owner
// is chosen.
module fifo_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] data_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic [N_REQ-1:0]       ack_o,
  input  logic                   fifo_full_i,
  output logic                   fifo_wr_en_o,
  output logic [WIDTH-1:0]       fifo_data_o,
  output logic                   busy_o
);

  // Owner index and burst counter widths (at least one bit each)
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [OW-1:0] LAST_OWNER_RST = OW'(N_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST       = CW'(BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_owner_q, last_owner_d;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;

  logic [WIDTH-1:0] data_slice [N_REQ];
  logic [N_REQ-1:0] owner_oh;
  logic [WIDTH-1:0] owner_data;
  logic             owner_req;
  logic             accept;
  logic             pick_valid;
  logic [OW-1:0]    pick_idx;

  // Split the flat data bus into per-requester words and decode the owner
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign data_slice[gi] = data_i[gi*WIDTH +: WIDTH];
      assign owner_oh[gi]   = (owner_q == OW'(gi));
    end
  endgenerate

  // Select the owner's data word with an AND-OR mux over the one-hot owner
  always_comb begin
    owner_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_oh[k]) begin
        owner_data = owner_data | data_slice[k];
      end
    end
  end

  assign owner_req = |(req_i & owner_oh);
  assign busy_o    = (state_q == GRANT);
  // A word moves only while granted, still requested and the fifo has room
  assign accept    = busy_o & owner_req & ~fifo_full_i;

  assign grant_o      = grant_q;
  assign ack_o        = accept ? owner_oh : '0;
  assign fifo_wr_en_o = accept;
  assign fifo_data_o  = busy_o ? owner_data : '0;

  // Round-robin search starting just after the previous owner; the loop runs
  // from the farthest offset to the nearest so the nearest requester wins
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last_owner_q) + i) % N_REQ;
      if (req_i[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = OW'(idx);
      end
    end
  end

  // Next-state logic for the arbitration FSM and burst bookkeeping
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = GRANT;
          owner_d     = pick_idx;
          grant_d     = N_REQ'(1) << pick_idx;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          // Owner ended its burst early; the count is left where it stopped
          state_d      = IDLE;
          grant_d      = '0;
          last_owner_d = owner_q;
        end else if (accept) begin
          if (burst_cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
            burst_cnt_d  = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset forces IDLE so every output drops immediately
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LAST_OWNER_RST;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single requester bursts,
// round-robin rotation, full stall, early drop and asynchronous reset.
module tb_fifo_wr_arbiter;

  logic         clk_i;
  logic         rst_i;
  logic [3:0]   req_i;
  logic [127:0] data_i;
  logic [3:0]   grant_o;
  logic [3:0]   ack_o;
  logic         fifo_full_i;
  logic         fifo_wr_en_o;
  logic [31:0]  fifo_data_o;
  logic         busy_o;

  logic [31:0]  dsl [4];
  int           checks;
  int           errors;

  assign data_i = {dsl[3], dsl[2], dsl[1], dsl[0]};

  fifo_wr_arbiter #(.N_REQ(4), .WIDTH(32), .BURST(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .data_i       (data_i),
    .grant_o      (grant_o),
    .ack_o        (ack_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          rr_cnt [4];
    int          n_wr;
    int          p;
    int          slot;
    int          w;
    int          own;
    logic [31:0] exp_data;

    checks      = 0;
    errors      = 0;
    n_wr        = 0;
    rst_i       = 1'b0;
    req_i       = 4'b1111;
    fifo_full_i = 1'b0;
    for (int k = 0; k < 4; k++) dsl[k] = 32'h11 * (k + 1);

    // Reset held with all requesting: nothing granted or written
    cyc();
    cyc();
    #1;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_ack", 32'(ack_o), 32'h0);
    chk("rst_data", fifo_data_o, 32'h0);
    $display("txn reset_hold grant=%b wr_en=%b", grant_o, fifo_wr_en_o);

    // Release: first arbitration picks requester 0
    rst_i = 1'b1;
    cyc();
    #1;
    chk("rel_grant", 32'(grant_o), 32'h1);
    chk("rel_busy", 32'(busy_o), 32'h1);
    chk("rel_wr_en", 32'(fifo_wr_en_o), 32'h1);
    chk("rel_data", fifo_data_o, 32'h11);
    $display("txn reset_release grant=%b data=%h", grant_o, fifo_data_o);
    req_i = 4'b0000;
    #1;
    chk("drop0_wr_en", 32'(fifo_wr_en_o), 32'h0);
    cyc();
    #1;
    chk("drop0_grant", 32'(grant_o), 32'h0);

    // Single requester 2: A0..A3, one idle cycle, A4..A7
    req_i  = 4'b0100;
    dsl[2] = 32'hA0;
    #1;
    chk("single_idle_wr", 32'(fifo_wr_en_o), 32'h0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        chk("single_gap_busy", 32'(busy_o), 32'h0);
        chk("single_gap_wr", 32'(fifo_wr_en_o), 32'h0);
        chk("single_gap_grant", 32'(grant_o), 32'h0);
        cyc();
      end
      dsl[2] = 32'hA0 + 32'(i);
      #1;
      chk("single_grant", 32'(grant_o), 32'h4);
      chk("single_wr", 32'(fifo_wr_en_o), 32'h1);
      chk("single_ack", 32'(ack_o), 32'h4);
      chk("single_data", fifo_data_o, 32'hA0 + 32'(i));
      $display("txn single word=%h wr_en=%b", fifo_data_o, fifo_wr_en_o);
      cyc();
    end
    req_i = 4'b0000;
    #1;
    chk("single_end_busy", 32'(busy_o), 32'h0);

    // Round robin after a fresh reset: owners 0,1,2,3,0
    rst_i = 1'b0;
    cyc();
    rst_i = 1'b1;
    req_i = 4'b1111;
    for (int k = 0; k < 4; k++) rr_cnt[k] = 0;
    for (int k = 0; k < 4; k++) dsl[k] = {8'(k), 24'(0)};
    #1;
    chk("rr_arb_wr", 32'(fifo_wr_en_o), 32'h0);
    cyc();
    for (int c = 1; c <= 25; c++) begin
      p    = c - 1;
      slot = p / 5;
      w    = p % 5;
      own  = slot % 4;
      for (int k = 0; k < 4; k++) dsl[k] = {8'(k), 24'(rr_cnt[k])};
      #1;
      if (c <= 20 && fifo_wr_en_o) n_wr++;
      if (w < 4) begin
        exp_data = {8'(own), 24'(rr_cnt[own])};
        chk("rr_wr", 32'(fifo_wr_en_o), 32'h1);
        chk("rr_ack", 32'(ack_o), 32'(4'b0001 << own));
        chk("rr_grant", 32'(grant_o), 32'(4'b0001 << own));
        chk("rr_data", fifo_data_o, exp_data);
        rr_cnt[own]++;
      end else begin
        chk("rr_idle_wr", 32'(fifo_wr_en_o), 32'h0);
        chk("rr_idle_grant", 32'(grant_o), 32'h0);
      end
      $display("txn rr cycle=%0d grant=%b wr_en=%b data=%h", c, grant_o, fifo_wr_en_o, fifo_data_o);
      if (c == 25) req_i = 4'b0010;
      cyc();
    end
    chk("rr_writes_in_20", 32'(n_wr), 32'd16);

    // Full stall: owner 1 after two words, fifo full for three cycles
    dsl[1] = 32'hB0;
    #1;
    chk("stall_w0", fifo_data_o, 32'hB0);
    chk("stall_w0_wr", 32'(fifo_wr_en_o), 32'h1);
    cyc();
    dsl[1] = 32'hB1;
    #1;
    chk("stall_w1", fifo_data_o, 32'hB1);
    chk("stall_w1_wr", 32'(fifo_wr_en_o), 32'h1);
    cyc();
    fifo_full_i = 1'b1;
    dsl[1]      = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_wr", 32'(fifo_wr_en_o), 32'h0);
      chk("stall_ack", 32'(ack_o), 32'h0);
      chk("stall_grant", 32'(grant_o), 32'h2);
      $display("txn stall cycle=%0d grant=%b wr_en=%b", i, grant_o, fifo_wr_en_o);
      cyc();
    end
    fifo_full_i = 1'b0;
    #1;
    chk("stall_w2", fifo_data_o, 32'hB2);
    chk("stall_w2_wr", 32'(fifo_wr_en_o), 32'h1);
    cyc();
    dsl[1] = 32'hB3;
    #1;
    chk("stall_w3", fifo_data_o, 32'hB3);
    chk("stall_w3_ack", 32'(ack_o), 32'h2);
    cyc();
    #1;
    chk("stall_release", 32'(grant_o), 32'h0);
    chk("stall_rel_busy", 32'(busy_o), 32'h0);
    $display("txn stall_release grant=%b", grant_o);

    // Early drop: owner 2 stops after one word, requester 3 follows
    req_i  = 4'b1100;
    dsl[2] = 32'hC0;
    dsl[3] = 32'hD0;
    cyc();
    #1;
    chk("drop_grant", 32'(grant_o), 32'h4);
    chk("drop_ack", 32'(ack_o), 32'h4);
    chk("drop_data", fifo_data_o, 32'hC0);
    cyc();
    req_i = 4'b1000;
    #1;
    chk("drop_nowr", 32'(fifo_wr_en_o), 32'h0);
    chk("drop_noack", 32'(ack_o), 32'h0);
    chk("drop_hold", 32'(grant_o), 32'h4);
    cyc();
    #1;
    chk("drop_idle", 32'(busy_o), 32'h0);
    chk("drop_idle_grant", 32'(grant_o), 32'h0);
    cyc();
    #1;
    chk("next_grant3", 32'(grant_o), 32'h8);
    chk("next_ack3", 32'(ack_o), 32'h8);
    chk("next_data3", fifo_data_o, 32'hD0);
    $display("txn early_drop next grant=%b data=%h", grant_o, fifo_data_o);

    // Asynchronous reset between edges during a burst
    rst_i = 1'b0;
    #1;
    chk("arst_grant", 32'(grant_o), 32'h0);
    chk("arst_wr", 32'(fifo_wr_en_o), 32'h0);
    chk("arst_busy", 32'(busy_o), 32'h0);
    chk("arst_data", fifo_data_o, 32'h0);
    req_i = 4'b1111;
    cyc();
    cyc();
    rst_i = 1'b1;
    cyc();
    #1;
    chk("arst_first_grant", 32'(grant_o), 32'h1);
    $display("txn async_reset first grant=%b", grant_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
